// File: rtl/rst_irq_controller.sv
// rst_irq_controller: turns video strobes into 8080 interrupt requests and
// supplies the matching RST opcode during the interrupt-acknowledge cycle.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   mid_screen, vblank   synchronized video strobes (rising edge = request)
//   inte                 CPU interrupt-enable flag
//   sync, status_in      CPU status strobe and status byte
//   dbin                 CPU data-bus-in strobe
//   iint                 interrupt request to the CPU (registered)
//   vector               RST opcode: 0xCF mid-screen, 0xD7 vblank (registered)
//   vector_oe            drive enable for vector (combinational: ACK & dbin)
//   ack_done             one-cycle pulse when an acknowledge completes
//   overrun              sticky lost-request flags {vblank, mid_screen}
module rst_irq_controller #(
  parameter int unsigned XLEN     = 8,
  parameter int unsigned INTA_BIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mid_screen,
  input  logic            vblank,
  input  logic            inte,
  input  logic            sync,
  input  logic [XLEN-1:0] status_in,
  input  logic            dbin,
  output logic            iint,
  output logic [XLEN-1:0] vector,
  output logic            vector_oe,
  output logic            ack_done,
  output logic [1:0]      overrun
);

  localparam logic [7:0] RST1_OP = 8'hCF;
  localparam logic [7:0] RST2_OP = 8'hD7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       ms_q;
  logic       vb_q;
  logic       dbin_q;
  logic       sel;
  logic [1:0] pending;
  logic [1:0] strobe_edge;
  logic [1:0] clr;
  logic       latch_sel;
  logic       ack_fire;
  logic       inta_seen;

  // Only the INTA bit of the status byte matters here.
  logic status_unused;
  assign status_unused = ^status_in;

  assign strobe_edge = {vblank & ~vb_q, mid_screen & ~ms_q};
  assign inta_seen   = sync & status_in[INTA_BIT];
  assign clr         = ack_fire ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign vector_oe   = (state == ACK) & dbin;

  // Next-state logic; sel is latched on ACK entry, pending cleared on ACK exit.
  always_comb begin
    state_next = state;
    latch_sel  = 1'b0;
    ack_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (pending != 2'b00) state_next = REQ;
      end
      REQ: begin
        if (pending == 2'b00) begin
          state_next = IDLE;
        end else if (inta_seen) begin
          state_next = ACK;
          latch_sel  = 1'b1;
        end
      end
      ACK: begin
        if (dbin_q && !dbin) begin
          state_next = IDLE;
          ack_fire   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Edge history, request bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_q     <= 1'b0;
      vb_q     <= 1'b0;
      dbin_q   <= 1'b0;
      pending  <= 2'b00;
      overrun  <= 2'b00;
      sel      <= 1'b0;
      iint     <= 1'b0;
      vector   <= XLEN'(RST1_OP);
      ack_done <= 1'b0;
    end else begin
      ms_q     <= mid_screen;
      vb_q     <= vblank;
      dbin_q   <= dbin;
      // A new edge on the source being cleared wins, so it is re-requested.
      pending  <= (pending & ~clr) | strobe_edge;
      // Overrun only when a request is truly dropped (not on a set/clear collision).
      overrun  <= overrun | (strobe_edge & pending & ~clr);
      iint     <= (state == REQ) & inte;
      ack_done <= ack_fire;
      if (latch_sel) begin
        sel    <= pending[1];
        vector <= pending[1] ? XLEN'(RST2_OP) : XLEN'(RST1_OP);
      end
    end
  end

endmodule
